// File: rtl/bus_bridge_pkg.sv
// rtl/bus_bridge_pkg.sv - shared width helpers and downsizer state type for the bus width bridge
package bus_bridge_pkg;

    function automatic int ratio_of(input int ratio_log);
        return 1 << ratio_log;
    endfunction

    function automatic int high_width_of(input int low_width, input int ratio_log);
        return low_width << ratio_log;
    endfunction

    function automatic int lane_idx_width(input int ratio_log);
        return ratio_log;
    endfunction

    typedef enum logic {
        DS_IDLE = 1'b0,
        DS_SEND = 1'b1
    } ds_state_t;

endpackage

// File: rtl/bus_pack_unit.sv
// rtl/bus_pack_unit.sv - upsizer packing narrow beats into strobed, auto-addressed wide words
module bus_pack_unit
    import bus_bridge_pkg::*;
#(
    parameter int RATIO_LOG      = 2,
    parameter int LOW_DATA_WIDTH = 8,
    parameter int ADDR_WIDTH     = 16,
    parameter int TIMEOUT        = 16
) (
    input  logic                                            clk,
    input  logic                                            rst_n,
    input  logic [LOW_DATA_WIDTH-1:0]                       low_rd_data,
    input  logic                                            low_rd_valid,
    output logic                                            low_rd_ready,
    input  logic                                            flush,
    output logic [high_width_of(LOW_DATA_WIDTH, RATIO_LOG)-1:0] high_wr_data,
    output logic [ratio_of(RATIO_LOG)-1:0]                  high_wr_strb,
    output logic [ADDR_WIDTH-1:0]                           high_wr_addr,
    output logic                                            high_wr_valid,
    input  logic                                            high_wr_ready
);

    localparam int RATIO  = ratio_of(RATIO_LOG);
    localparam int LIW    = lane_idx_width(RATIO_LOG);
    localparam int IDLE_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [LIW-1:0]    LANE_LAST = LIW'(RATIO - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam bit                TO_EN     = (TIMEOUT != 0);

    logic [LIW-1:0]    fill_cnt;
    logic [IDLE_W-1:0] idle_cnt;
    logic              accept;
    logic              partial;
    logic              timed_out;
    logic              issue;

    assign low_rd_ready = !high_wr_valid;
    assign accept       = low_rd_valid && low_rd_ready;
    assign partial      = (fill_cnt != '0);
    assign timed_out    = TO_EN && !accept && partial && (idle_cnt == IDLE_LAST);
    // A flush on the same cycle as an accept still packs that lane before issuing.
    assign issue        = !high_wr_valid &&
                          ((accept && ((fill_cnt == LANE_LAST) || flush)) ||
                           (!accept && partial && (flush || timed_out)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            high_wr_data  <= '0;
            high_wr_strb  <= '0;
            high_wr_addr  <= '0;
            high_wr_valid <= 1'b0;
            fill_cnt      <= '0;
            idle_cnt      <= '0;
        end else if (high_wr_valid) begin
            if (high_wr_ready) begin
                high_wr_valid <= 1'b0;
                high_wr_addr  <= high_wr_addr + 1'b1;
                high_wr_data  <= '0;
                high_wr_strb  <= '0;
                fill_cnt      <= '0;
                idle_cnt      <= '0;
            end
        end else begin
            if (accept) begin
                for (int i = 0; i < RATIO; i++) begin
                    if (fill_cnt == LIW'(i)) begin
                        high_wr_data[i*LOW_DATA_WIDTH +: LOW_DATA_WIDTH] <= low_rd_data;
                        high_wr_strb[i] <= 1'b1;
                    end
                end
                fill_cnt <= fill_cnt + 1'b1;
                idle_cnt <= '0;
            end else if (partial && TO_EN) begin
                idle_cnt <= idle_cnt + 1'b1;
            end
            if (issue) begin
                high_wr_valid <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_width_bridge.sv
// rtl/bus_width_bridge.sv - bidirectional narrow/wide bus width converter with handshakes
module bus_width_bridge
    import bus_bridge_pkg::*;
#(
    parameter int RATIO_LOG      = 2,
    parameter int LOW_DATA_WIDTH = 8,
    parameter int ADDR_WIDTH     = 16,
    parameter int TIMEOUT        = 16
) (
    input  logic                                            clk,
    input  logic                                            rst_n,
    input  logic [high_width_of(LOW_DATA_WIDTH, RATIO_LOG)-1:0] high_rd_data,
    input  logic                                            high_rd_valid,
    output logic                                            high_rd_ready,
    output logic [LOW_DATA_WIDTH-1:0]                       low_wr_data,
    output logic                                            low_wr_valid,
    output logic                                            low_wr_last,
    input  logic                                            low_wr_ready,
    input  logic [LOW_DATA_WIDTH-1:0]                       low_rd_data,
    input  logic                                            low_rd_valid,
    output logic                                            low_rd_ready,
    input  logic                                            flush,
    output logic [high_width_of(LOW_DATA_WIDTH, RATIO_LOG)-1:0] high_wr_data,
    output logic [ratio_of(RATIO_LOG)-1:0]                  high_wr_strb,
    output logic [ADDR_WIDTH-1:0]                           high_wr_addr,
    output logic                                            high_wr_valid,
    input  logic                                            high_wr_ready
);

    localparam int RATIO           = ratio_of(RATIO_LOG);
    localparam int HIGH_DATA_WIDTH = high_width_of(LOW_DATA_WIDTH, RATIO_LOG);
    localparam int LIW             = lane_idx_width(RATIO_LOG);
    localparam logic [LIW-1:0] BEAT_LAST = LIW'(RATIO - 1);

    ds_state_t                  ds_state;
    logic [HIGH_DATA_WIDTH-1:0] ds_word;
    logic [LIW-1:0]             beat_cnt;
    logic                       sending;
    logic                       last_done;

    assign sending       = (ds_state == DS_SEND);
    assign low_wr_valid  = sending;
    assign low_wr_last   = sending && (beat_cnt == BEAT_LAST);
    assign last_done     = low_wr_last && low_wr_ready;
    // Accepting on the final beat lets consecutive words stream with no bubble.
    assign high_rd_ready = !sending || last_done;

    always_comb begin
        low_wr_data = '0;
        for (int i = 0; i < RATIO; i++) begin
            if (beat_cnt == LIW'(i)) begin
                low_wr_data = ds_word[i*LOW_DATA_WIDTH +: LOW_DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ds_state <= DS_IDLE;
            ds_word  <= '0;
            beat_cnt <= '0;
        end else begin
            case (ds_state)
                DS_IDLE: begin
                    if (high_rd_valid) begin
                        ds_word  <= high_rd_data;
                        beat_cnt <= '0;
                        ds_state <= DS_SEND;
                    end
                end
                DS_SEND: begin
                    if (low_wr_ready) begin
                        if (beat_cnt != BEAT_LAST) begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end else if (high_rd_valid) begin
                            ds_word  <= high_rd_data;
                            beat_cnt <= '0;
                        end else begin
                            ds_state <= DS_IDLE;
                        end
                    end
                end
            endcase
        end
    end

    bus_pack_unit #(
        .RATIO_LOG      (RATIO_LOG),
        .LOW_DATA_WIDTH (LOW_DATA_WIDTH),
        .ADDR_WIDTH     (ADDR_WIDTH),
        .TIMEOUT        (TIMEOUT)
    ) u_pack (
        .clk           (clk),
        .rst_n         (rst_n),
        .low_rd_data   (low_rd_data),
        .low_rd_valid  (low_rd_valid),
        .low_rd_ready  (low_rd_ready),
        .flush         (flush),
        .high_wr_data  (high_wr_data),
        .high_wr_strb  (high_wr_strb),
        .high_wr_addr  (high_wr_addr),
        .high_wr_valid (high_wr_valid),
        .high_wr_ready (high_wr_ready)
    );

endmodule
